// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port arbiter in front of a single sdram_basemod.
// Each side speaks the basemod call/done handshake (bit1 write, bit0 read).
// Exactly one command is outstanding at a time; the grant is held until the
// basemod's matching done bit is seen, then a one-cycle done pulse is
// returned to the owning port, followed by one release cycle.
// Optional build macro SDRAM_ARB_FIXED_PRIO_EN: port 0 always wins contention.
module sdram_arbiter #(
  parameter int AW = 24,
  parameter int DW = 16
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic [1:0]    iCall0,
  output logic [1:0]    oDone0,
  input  logic [AW-1:0] iAddr0,
  input  logic [DW-1:0] iData0,
  output logic [DW-1:0] oData0,
  input  logic [1:0]    iCall1,
  output logic [1:0]    oDone1,
  input  logic [AW-1:0] iAddr1,
  input  logic [DW-1:0] iData1,
  output logic [DW-1:0] oData1,
  output logic [1:0]    oCall,
  input  logic [1:0]    iDone,
  output logic [AW-1:0] oAddr,
  output logic [DW-1:0] oData,
  input  logic [DW-1:0] iData,
  output logic          oBusy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DONE, S_RELEASE} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;   // port granted most recently
  logic          g_q, g_d;         // port owning the current grant
  logic          wr_q, wr_d;       // current op is a write
  logic [1:0]    call_q, call_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [DW-1:0] rdat0_q, rdat0_d;
  logic [DW-1:0] rdat1_q, rdat1_d;
  logic [1:0]    done0_q, done0_d;
  logic [1:0]    done1_q, done1_d;
  logic          busy_q, busy_d;

  logic          req0, req1, pick1;
  logic [1:0]    sel_call;

  assign req0 = |iCall0;
  assign req1 = |iCall1;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  // Port 1 only ever gets the basemod when port 0 is silent.
  assign pick1 = req1 & ~req0;
`else
  // Round robin: under contention take the port that did not go last.
  assign pick1 = req1 & (~req0 | ~last_q);
`endif

  assign sel_call = pick1 ? iCall1 : iCall0;

  // Next-state and registered-output computation for the grant FSM.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    g_d     = g_q;
    wr_d    = wr_q;
    call_d  = call_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat0_d = rdat0_q;
    rdat1_d = rdat1_q;
    done0_d = 2'b00;
    done1_d = 2'b00;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          // Both call bits set is executed as a write.
          g_d     = pick1;
          wr_d    = sel_call[1];
          call_d  = {sel_call[1], ~sel_call[1]};
          addr_d  = pick1 ? iAddr1 : iAddr0;
          wdat_d  = pick1 ? iData1 : iData0;
          last_d  = pick1;
          busy_d  = 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // Only the done bit matching our op ends the command.
        if (wr_q ? iDone[1] : iDone[0]) begin
          call_d = 2'b00;
          if (!wr_q) begin
            if (g_q) rdat1_d = iData;
            else     rdat0_d = iData;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (g_q) done1_d = {wr_q, ~wr_q};
        else     done0_d = {wr_q, ~wr_q};
        state_d = S_RELEASE;
      end
      default: begin
        // Settling cycle: requester drops its call, basemod drops done.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      g_q     <= 1'b0;
      wr_q    <= 1'b0;
      call_q  <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat0_q <= '0;
      rdat1_q <= '0;
      done0_q <= '0;
      done1_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      g_q     <= g_d;
      wr_q    <= wr_d;
      call_q  <= call_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat0_q <= rdat0_d;
      rdat1_q <= rdat1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign oCall  = call_q;
  assign oAddr  = addr_q;
  assign oData  = wdat_q;
  assign oData0 = rdat0_q;
  assign oData1 = rdat1_q;
  assign oDone0 = done0_q;
  assign oDone1 = done1_q;
  assign oBusy  = busy_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small basemod model (fixed latency,
// associative memory; unwritten locations read back as addr[15:0]^16'h5A5A).
module tb_sdram_arbiter;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic [1:0]    iCall0, iCall1, oDone0, oDone1, oCall, iDone;
  logic [AW-1:0] iAddr0, iAddr1, oAddr;
  logic [DW-1:0] iData0, iData1, oData0, oData1, oData, iData;
  logic          oBusy;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .iCall0(iCall0), .oDone0(oDone0), .iAddr0(iAddr0), .iData0(iData0), .oData0(oData0),
    .iCall1(iCall1), .oDone1(oDone1), .iAddr1(iAddr1), .iData1(iData1), .oData1(oData1),
    .oCall(oCall), .iDone(iDone), .oAddr(oAddr), .oData(oData), .iData(iData), .oBusy(oBusy)
  );

  always #5 CLOCK = ~CLOCK;

  // Basemod model: after LAT idle cycles of a held call, pulse the op's done bit.
  logic [DW-1:0] mem [logic [AW-1:0]];
  int cnt;
  always @(posedge CLOCK) begin
    if (!RESET) begin
      iDone <= 2'b00;
      cnt   <= 0;
    end else if (iDone != 2'b00) begin
      iDone <= 2'b00;
    end else if (oCall != 2'b00) begin
      if (cnt == LAT) begin
        cnt <= 0;
        if (oCall[1]) begin
          iDone <= 2'b10;
          mem[oAddr] = oData;
        end else begin
          iDone <= 2'b01;
          iData <= mem.exists(oAddr) ? mem[oAddr] : (oAddr[15:0] ^ 16'h5A5A);
        end
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nc();
    @(negedge CLOCK);
  endtask

  // Advance until the model's done is visible (bounded).
  task automatic wait_idone();
    int k = 0;
    while (iDone == 2'b00 && k < 40) begin
      nc();
      k++;
    end
    chk("idone_seen", {31'd0, iDone != 2'b00}, 32'd1);
  endtask

  int gp[$], dp[$], gaps[$];
  int exp_g[4];
  int overlap, lowrun;
  logic [1:0] pc;

  initial begin
    RESET = 1'b0; iCall0 = 0; iCall1 = 0; iAddr0 = 0; iAddr1 = 0; iData0 = 0; iData1 = 0;
    iData = 0;
    nc(); nc();
    chk("rst_call", {30'd0, oCall}, 0);
    chk("rst_busy", {31'd0, oBusy}, 0);
    chk("rst_done", {28'd0, oDone0, oDone1}, 0);
    chk("rst_addr", {8'd0, oAddr}, 0);
    chk("rst_rdat", {oData0, oData1}, 0);
    RESET = 1'b1;
    nc();

    // Port 0 write
    iCall0 = 2'b10; iAddr0 = 24'h000010; iData0 = 16'hABCD;
    nc();
    chk("w_call", {30'd0, oCall}, 32'h2);
    chk("w_addr", {8'd0, oAddr}, 32'h10);
    chk("w_data", {16'd0, oData}, 32'hABCD);
    chk("w_busy", {31'd0, oBusy}, 1);
    wait_idone();
    chk("w_idone", {30'd0, iDone}, 32'h2);
    nc();
    chk("w_call_drop", {30'd0, oCall}, 0);
    chk("w_done_early", {30'd0, oDone0}, 0);
    nc();
    chk("w_done0", {30'd0, oDone0}, 32'h2);
    chk("w_done1", {30'd0, oDone1}, 0);
    iCall0 = 2'b00;
    nc();
    chk("w_done_clr", {30'd0, oDone0}, 0);
    chk("w_busy_clr", {31'd0, oBusy}, 0);
    nc();

    // Port 1 read of the word just written
    iCall1 = 2'b01; iAddr1 = 24'h000010;
    nc();
    chk("r_call", {30'd0, oCall}, 32'h1);
    wait_idone();
    nc();
    chk("r_done_early", {30'd0, oDone1}, 0);
    nc();
    chk("r_done1", {30'd0, oDone1}, 32'h1);
    chk("r_data1", {16'd0, oData1}, 32'hABCD);
    iCall1 = 2'b00;
    nc();
    chk("r_done_clr", {30'd0, oDone1}, 0);
    chk("r_data1_hold", {16'd0, oData1}, 32'hABCD);
    chk("r_data0_untouched", {16'd0, oData0}, 0);
    nc();

    // Contention: both ports hold read calls
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    iCall0 = 2'b01; iAddr0 = 24'h000020;
    iCall1 = 2'b01; iAddr1 = 24'h000030;
    pc = oCall; overlap = 0; lowrun = 0;
    for (int k = 0; k < 300 && dp.size() < 4; k++) begin
      nc();
      if (oCall != 2'b00 && pc == 2'b00) gp.push_back(oAddr == 24'h000030 ? 1 : 0);
      pc = oCall;
      if (oDone0 != 2'b00 && oDone1 != 2'b00) overlap++;
      if (oDone0 != 2'b00) dp.push_back(0);
      if (oDone1 != 2'b00) dp.push_back(1);
      if (gp.size() > 0 && !oBusy) lowrun++;
      else if (oBusy && lowrun > 0) begin
        gaps.push_back(lowrun);
        lowrun = 0;
      end
    end
    iCall0 = 2'b00; iCall1 = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("c_grant%0d", i), (i < gp.size()) ? gp[i] : 9, exp_g[i]);
      chk($sformatf("c_done%0d", i), (i < dp.size()) ? dp[i] : 9, exp_g[i]);
    end
    chk("c_overlap", overlap, 0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("c_gap%0d", i), (i < gaps.size()) ? gaps[i] : 9, 1);
    chk("c_data0", {16'd0, oData0}, 32'h5A7A);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    chk("c_data1", {16'd0, oData1}, 32'hABCD);
`else
    chk("c_data1", {16'd0, oData1}, 32'h5A6A);
`endif
    nc(); nc();

    // Both call bits set -> write
    iCall0 = 2'b11; iAddr0 = 24'h000040; iData0 = 16'h1234;
    nc();
    chk("ww_call", {30'd0, oCall}, 32'h2);
    wait_idone();
    nc(); nc();
    chk("ww_done0", {30'd0, oDone0}, 32'h2);
    iCall0 = 2'b00;
    nc(); nc();

    // Reset during GRANT, then contention must go to port 0
    iCall0 = 2'b01; iAddr0 = 24'h000050;
    nc();
    chk("rg_call", {30'd0, oCall}, 32'h1);
    RESET = 1'b0; iCall0 = 2'b00;
    nc();
    chk("rg_call0", {30'd0, oCall}, 0);
    chk("rg_busy0", {31'd0, oBusy}, 0);
    chk("rg_addr0", {8'd0, oAddr}, 0);
    chk("rg_wdat0", {16'd0, oData}, 0);
    chk("rg_rdat0", {oData0, oData1}, 0);
    chk("rg_done0", {28'd0, oDone0, oDone1}, 0);
    RESET = 1'b1;
    iCall0 = 2'b01; iAddr0 = 24'h000060;
    iCall1 = 2'b01; iAddr1 = 24'h000070;
    nc();
    chk("rg_grant_addr", {8'd0, oAddr}, 32'h60);
    chk("rg_grant_call", {30'd0, oCall}, 32'h1);
    wait_idone();
    nc(); nc();
    chk("rg_done0_pulse", {30'd0, oDone0}, 32'h1);
    chk("rg_rdat0_val", {16'd0, oData0}, 32'h5A3A);
    iCall0 = 2'b00; iCall1 = 2'b00;
    nc(); nc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-port round-robin arbiter that shares one sdram_basemod between two requesters.
- Each requester uses the basemod's own call/done handshake: iCall[1] = write, iCall[0] = read, one-cycle oDone pulse.
- Sits between the application FSMs (test/UART logic, frame writers) and sdram_basemod in the CLOCK1 domain.
- Forwards address, write data and read data, and guarantees exactly one outstanding SDRAM command.

Parameters:
AW, 24, address width (matches basemod iAddr)
DW, 16, data width (matches basemod iData/oData)

Ports:
CLOCK  in  1  system clock (basemod clock, 133 MHz)
RESET  in  1  synchronous, active-low reset
iCall0  in  2  port 0 request; bit1 write, bit0 read
oDone0  out  2  port 0 completion pulse; bit1 write, bit0 read
iAddr0  in  AW  port 0 address
iData0  in  DW  port 0 write data
oData0  out  DW  port 0 read data, valid from the oDone0[0] pulse onward
iCall1  in  2  port 1 request (as port 0)
oDone1  out  2  port 1 completion pulse
iAddr1  in  AW  port 1 address
iData1  in  DW  port 1 write data
oData1  out  DW  port 1 read data
oCall  out  2  to basemod iCall
iDone  in  2  from basemod oDone
oAddr  out  AW  to basemod iAddr
oData  out  DW  to basemod iData
iData  in  DW  from basemod oData
oBusy  out  1  high while a grant is active (GRANT/DONE/RELEASE)

Behaviour:
- Reset (RESET low at posedge), all outputs 0: oCall, oDone0/1, oAddr, oData, oData0/1, oBusy. Round-robin pointer last=1, so port 0 is preferred first. Reset mid-transaction abandons the command immediately and oCall drops on that edge.
- Requester protocol:
  - Holds iCallN non-zero and addr/data stable until it sees oDoneN non-zero.
  - Clears iCallN on that same edge.
  - If both call bits are set, the request is treated as a write.
- States: IDLE, GRANT, DONE, RELEASE.
- IDLE:
  - Request valid when iCallN != 0.
  - If only one port is requesting, grant it.
  - If both are requesting, grant the port != last.
  - On grant: latch port index g, op (W if bit1, else R), addr and data into oAddr/oData; oCall <= {W, R}; last <= g; oBusy <= 1; go to GRANT.
- GRANT:
  - Hold oCall, oAddr and oData constant.
  - When the iDone bit matching the op is high: oCall <= 0. For a read, also latch iData into oDataG. Go to DONE.
  - Any iDone bit not matching the op is ignored.
- DONE:
  - oDoneG <= op bits for exactly one cycle. This pulse appears one cycle after iDone.
  - Go to RELEASE.
- RELEASE:
  - oDone cleared. One idle cycle so the requester's dropped call and the basemod's done deassertion settle.
  - oBusy <= 0; go to IDLE.
- Throughput: minimum 3 arbiter cycles overhead per access beyond basemod latency. Under continuous contention the ports strictly alternate.
- Requests are never preempted. A request arriving during GRANT/DONE/RELEASE waits; it is evaluated in IDLE.
- oData0/oData1 hold their last read value until the next read completion on that port. Writes do not alter them.
- A requester that drops its call before done (protocol violation) does not abort the command. The command completes and the done pulse is still issued.
- Never more than one oDone bit high across both ports in any cycle.

Optional Feature:
- Macro: SDRAM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins contention; the pointer is unused. Port 1 is granted only when iCall0 == 0 in IDLE. Port 1 may starve.
- Undefined: round-robin exactly as in Behaviour.

Test Plan:
- Port 0 write, addr 24'h000010, data 16'hABCD, port 1 idle:
  - oCall = 2'b10 with oAddr = 24'h000010, oData = 16'hABCD.
  - Bench basemod model pulses iDone[1] → oCall = 0 on that edge; oDone0 = 2'b10 for one cycle, one cycle later.
- Port 1 read, addr 24'h000010, model returns 16'hABCD:
  - oCall = 2'b01.
  - oData1 = 16'hABCD when oDone1 = 2'b01; value held after the pulse.
- Both ports continuously request reads:
  - Grants in order 0,1,0,1.
  - oDone pulses alternate ports and never overlap.
  - oBusy low exactly one cycle between grants.
- Port 0 iCall0 = 2'b11:
  - Executed as a write (oCall = 2'b10); oDone0 = 2'b10.
- RESET low for 1 cycle while in GRANT:
  - All outputs 0 next cycle; the next contended grant goes to port 0.
- With SDRAM_ARB_FIXED_PRIO_EN defined, both ports requesting continuously:
  - Port 0 granted every time. Port 1 is granted only after port 0 drops its call.
